// File: rtl/pat_sequencer.sv
// pat_sequencer: walks LED indices 0..NUM_LEDS-1 against one active pattern
// generator per frame and hands each colour to the LED driver over valid/ready.
// Optional build macro PAT_SEQ_OVERRUN_COUNT_EN: count frame_start pulses that
// arrive while a frame is still in flight (otherwise overrun_count_out is 0).
module pat_sequencer #(
  parameter int NUM_LEDS       = 20,
  parameter int COLOR_WIDTH    = 8,
  parameter int NUM_PATTERNS   = 4,
  parameter int DWELL_FRAMES   = 64,
  parameter int TIMEOUT_CYCLES = 8,
  localparam int CounterWidth  = $clog2(NUM_LEDS),
  localparam int SelWidth      = $clog2(NUM_PATTERNS)
) (
  input  logic                                clk_in,
  input  logic                                rst_n_in,
  input  logic                                frame_start_in,
  input  logic                                manual_mode_in,
  input  logic [SelWidth-1:0]                 manual_sel_in,
  output logic [CounterWidth-1:0]             pat_led_request_out,
  input  logic [NUM_PATTERNS*COLOR_WIDTH-1:0] pat_red_in,
  input  logic [NUM_PATTERNS*COLOR_WIDTH-1:0] pat_green_in,
  input  logic [NUM_PATTERNS*COLOR_WIDTH-1:0] pat_blue_in,
  input  logic [NUM_PATTERNS-1:0]             pat_valid_in,
  output logic [COLOR_WIDTH-1:0]              red_out,
  output logic [COLOR_WIDTH-1:0]              green_out,
  output logic [COLOR_WIDTH-1:0]              blue_out,
  output logic [CounterWidth-1:0]             led_index_out,
  output logic                                color_valid_out,
  input  logic                                color_ready_in,
  output logic                                frame_done_out,
  output logic [SelWidth-1:0]                 active_pattern_out,
  output logic                                timeout_err_out,
  output logic [7:0]                          overrun_count_out
);

  localparam int TcntWidth  = $clog2(TIMEOUT_CYCLES);
  localparam int DwellWidth = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, FRAME_END} state_t;

  state_t                  state_q, state_d;
  logic [CounterWidth-1:0] led_idx_q, led_index_q;
  logic [SelWidth-1:0]     active_q, auto_ptr_q, sel_mapped;
  logic [TcntWidth-1:0]    tcnt_q;
  logic [DwellWidth-1:0]   dwell_q;
  logic [COLOR_WIDTH-1:0]  red_q, green_q, blue_q;
  logic                    terr_q;
  logic                    fetch_hit, fetch_to, last_led, dwell_last;

  // Per-pattern views of the flattened colour buses
  logic [NUM_PATTERNS-1:0][COLOR_WIDTH-1:0] red_arr, green_arr, blue_arr;
  assign red_arr   = pat_red_in;
  assign green_arr = pat_green_in;
  assign blue_arr  = pat_blue_in;

  // Out-of-range manual selects fall back to pattern 0
  assign sel_mapped = (32'(manual_sel_in) >= NUM_PATTERNS) ? '0 : manual_sel_in;
  assign fetch_hit  = pat_valid_in[active_q];
  assign fetch_to   = (tcnt_q == TcntWidth'(TIMEOUT_CYCLES - 1));
  assign last_led   = (led_idx_q == CounterWidth'(NUM_LEDS - 1));
  assign dwell_last = (dwell_q == DwellWidth'(DWELL_FRAMES - 1));

  assign pat_led_request_out = led_idx_q;
  assign red_out             = red_q;
  assign green_out           = green_q;
  assign blue_out            = blue_q;
  assign led_index_out       = led_index_q;
  assign color_valid_out     = (state_q == PRESENT);
  assign frame_done_out      = (state_q == FRAME_END);
  assign active_pattern_out  = active_q;
  assign timeout_err_out     = terr_q;

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic; valid beats timeout when both hit in the same FETCH cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (frame_start_in) state_d = FETCH;
      FETCH:     if (fetch_hit || fetch_to) state_d = PRESENT;
      PRESENT:   if (color_ready_in) state_d = last_led ? FRAME_END : FETCH;
      FRAME_END: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath: LED walk, colour capture, fetch timeout, dwell/auto-rotate
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      led_idx_q   <= '0;
      led_index_q <= '0;
      active_q    <= '0;
      auto_ptr_q  <= '0;
      tcnt_q      <= '0;
      dwell_q     <= '0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      terr_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (frame_start_in) begin
          led_idx_q <= '0;
          active_q  <= manual_mode_in ? sel_mapped : auto_ptr_q;
        end
        FETCH: begin
          if (fetch_hit) begin
            red_q       <= red_arr[active_q];
            green_q     <= green_arr[active_q];
            blue_q      <= blue_arr[active_q];
            led_index_q <= led_idx_q;
            tcnt_q      <= '0;
          end else if (fetch_to) begin
            // Generator never answered: present black and flag it
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            led_index_q <= led_idx_q;
            terr_q      <= 1'b1;
            tcnt_q      <= '0;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        PRESENT: if (color_ready_in && !last_led) led_idx_q <= led_idx_q + 1'b1;
        FRAME_END: if (!manual_mode_in) begin
          // Manual mode freezes the rotation so it resumes where it left off
          if (dwell_last) begin
            dwell_q    <= '0;
            auto_ptr_q <= (auto_ptr_q == SelWidth'(NUM_PATTERNS - 1)) ? '0 : auto_ptr_q + 1'b1;
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PAT_SEQ_OVERRUN_COUNT_EN
  logic [7:0] ovr_q;
  // Saturating count of frame starts dropped because a frame was in flight
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                                             ovr_q <= '0;
    else if (frame_start_in && state_q != IDLE && ovr_q != 8'hFF) ovr_q <= ovr_q + 1'b1;
  end
  assign overrun_count_out = ovr_q;
`else
  assign overrun_count_out = '0;
`endif

endmodule

// File: tb/tb_pat_sequencer.sv
// Directed bench for pat_sequencer: four registered pattern generators that
// return (p, idx, 0); checks latency, colours, rotation, backpressure,
// fetch timeout, ignored frame starts and mid-frame reset.
// Cycle t counts clock periods after the one in which frame_start_in is high.
module tb_pat_sequencer;
  localparam int NP = 4;
  localparam int CW = 5;

  logic                 clk_in, rst_n_in, frame_start_in, manual_mode_in;
  logic [1:0]           manual_sel_in;
  logic [CW-1:0]        pat_led_request_out;
  logic [NP*8-1:0]      pat_red_in, pat_green_in, pat_blue_in;
  logic [NP-1:0]        pat_valid_in;
  logic [7:0]           red_out, green_out, blue_out;
  logic [CW-1:0]        led_index_out;
  logic                 color_valid_out, color_ready_in, frame_done_out;
  logic [1:0]           active_pattern_out;
  logic                 timeout_err_out;
  logic [7:0]           overrun_count_out;

  int n_chk = 0;
  int n_fail = 0;

  logic                 gen_run;
  logic [NP-1:0]        gen_en, gen_v;
  logic [CW-1:0]        gen_idx [NP];

`ifdef PAT_SEQ_OVERRUN_COUNT_EN
  localparam int OVR_HIT = 1;
`else
  localparam int OVR_HIT = 0;
`endif

  pat_sequencer #(.DWELL_FRAMES(2)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .frame_start_in(frame_start_in),
    .manual_mode_in(manual_mode_in), .manual_sel_in(manual_sel_in),
    .pat_led_request_out(pat_led_request_out),
    .pat_red_in(pat_red_in), .pat_green_in(pat_green_in), .pat_blue_in(pat_blue_in),
    .pat_valid_in(pat_valid_in),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .led_index_out(led_index_out), .color_valid_out(color_valid_out),
    .color_ready_in(color_ready_in), .frame_done_out(frame_done_out),
    .active_pattern_out(active_pattern_out), .timeout_err_out(timeout_err_out),
    .overrun_count_out(overrun_count_out)
  );

  initial begin
    clk_in = 0;
    forever #5 clk_in = ~clk_in;
  end

  // Generator model: one-cycle registered response, valid only while the
  // registered index still matches the broadcast request
  always_ff @(posedge clk_in) begin
    for (int p = 0; p < NP; p++) begin
      gen_idx[p] <= pat_led_request_out;
      gen_v[p]   <= gen_run && gen_en[p];
    end
  end

  always_comb begin
    pat_valid_in = '0;
    pat_red_in   = '0;
    pat_green_in = '0;
    pat_blue_in  = '0;
    for (int p = 0; p < NP; p++) begin
      pat_valid_in[p]       = gen_v[p] && (gen_idx[p] == pat_led_request_out);
      pat_red_in[p*8 +: 8]   = 8'(p);
      pat_green_in[p*8 +: 8] = 8'(gen_idx[p]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req"}, pat_led_request_out, 0);
    chk({tag, "_rgb"}, {red_out, green_out, blue_out}, 0);
    chk({tag, "_idx"}, led_index_out, 0);
    chk({tag, "_valid"}, color_valid_out, 0);
    chk({tag, "_done"}, frame_done_out, 0);
    chk({tag, "_apat"}, active_pattern_out, 0);
    chk({tag, "_terr"}, timeout_err_out, 0);
    chk({tag, "_ovr"}, overrun_count_out, 0);
  endtask

  // One frame. stall_led: hold ready low 5 cycles on that LED; pulse_led: pulse
  // frame_start (and switch manual_sel_in to 0) there; abort_led: reset there.
  task automatic run_frame(input int exp_pat, input bit tmo, input int stall_led,
                           input int pulse_led, input int abort_led);
    int t, exp_idx, stall_n, first_t, n_hs, exp_done;
    bit done, stalled, pulsed;
    exp_idx = 0; stall_n = 0; first_t = -1; n_hs = 0;
    done = 0; stalled = 0; pulsed = 0;
    exp_done = tmo ? 181 : (61 + ((stall_led >= 0) ? 5 : 0));
    frame_start_in = 1;
    @(negedge clk_in);
    t = 1;
    gen_run = 1;
    while (!done && t < 400) begin
      frame_start_in = 0;
      color_ready_in = 1;
      if (stalled) chk("hold_valid", color_valid_out, 1);
      stalled = 0;
      if (color_valid_out) begin
        if (first_t < 0) begin
          first_t = t;
          chk("first_lat", t, tmo ? 9 : 3);
          chk("active_pat", active_pattern_out, exp_pat);
        end
        chk("led_index", led_index_out, exp_idx);
        chk("red", red_out, tmo ? 0 : exp_pat);
        chk("green", green_out, tmo ? 0 : exp_idx);
        chk("blue", blue_out, 0);
        if (exp_idx == abort_led) begin
          rst_n_in = 0;
          gen_run = 0;
          #1;
          chk_idle("abort");
          repeat (2) begin
            @(negedge clk_in);
            chk("abort_nodone", frame_done_out, 0);
          end
          rst_n_in = 1;
          repeat (3) begin
            @(negedge clk_in);
            chk("abort_idle", {color_valid_out, frame_done_out}, 0);
          end
          return;
        end
        if (!pulsed && exp_idx == pulse_led) begin
          frame_start_in = 1;
          manual_sel_in  = 0;
          pulsed = 1;
        end
        if (exp_idx == stall_led && stall_n < 5) begin
          color_ready_in = 0;
          stall_n++;
          stalled = 1;
        end else begin
          exp_idx++;
          n_hs++;
        end
      end
      if (frame_done_out) begin
        chk("done_cycle", t, exp_done);
        chk("hs_count", n_hs, 20);
        chk("active_end", active_pattern_out, exp_pat);
        done = 1;
      end else begin
        @(negedge clk_in);
        t++;
      end
    end
    chk("frame_bound", done, 1);
    gen_run = 0;
    color_ready_in = 1;
    @(negedge clk_in);
    chk("done_pulse", frame_done_out, 0);
    @(negedge clk_in);
  endtask

  int auto_seq [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

  initial begin
    rst_n_in = 0; frame_start_in = 0; manual_mode_in = 0; manual_sel_in = 0;
    color_ready_in = 1; gen_run = 0; gen_en = '1;
    #1;
    chk_idle("reset");
    repeat (2) @(negedge clk_in);
    rst_n_in = 1;
    @(negedge clk_in);

    // Auto rotation with dwell of 2 frames, wrapping 3 -> 0; stall on LED 7 in frame 3
    for (int f = 0; f < 9; f++) run_frame(auto_seq[f], 0, (f == 2) ? 7 : -1, -1, -1);
    chk("terr_clean", timeout_err_out, 0);

    // Pattern 2 silent: every LED times out to black, error sticks
    manual_mode_in = 1; manual_sel_in = 2; gen_en[2] = 0;
    run_frame(2, 1, -1, -1, -1);
    chk("terr_set", timeout_err_out, 1);
    gen_en[2] = 1;

    // Mid-frame frame_start ignored; selection switched to 0 applies next frame
    manual_sel_in = 1;
    run_frame(1, 0, -1, 10, -1);
    chk("ovr_count", overrun_count_out, OVR_HIT);
    run_frame(0, 0, -1, -1, -1);

    // Back to auto: rotation was frozen at pointer 0 with one frame of dwell used
    manual_mode_in = 0;
    run_frame(0, 0, -1, -1, -1);
    run_frame(1, 0, -1, -1, -1);
    chk("terr_sticky", timeout_err_out, 1);
    chk("ovr_hold", overrun_count_out, OVR_HIT);

    // Reset during PRESENT on LED 5, then a clean frame from index 0 / pattern 0
    run_frame(1, 0, -1, -1, 5);
    run_frame(0, 0, -1, -1, -1);
    chk("terr_after_rst", timeout_err_out, 0);
    chk("ovr_after_rst", overrun_count_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=%0d exp=%0d", 0, 1);
    $fatal(1, "watchdog expired");
  end
endmodule
